// File: rtl/frac_div_mc.sv
// frac_div_mc: multi-channel fractional-N divider with PWM output and double-buffered settings.
// Defining FRAC_DIV_ALIGN_EN adds an `align` strobe that phase-aligns all channels on the next tick.
module frac_div_mc #(
    parameter int NCH   = 2,
    parameter int WIDTH = 17,
    parameter int FW    = 8
) (
    input  logic                 sys_clk,
    input  logic                 sync_rst,
    input  logic                 clk_in,
    input  logic [NCH-1:0]       en,
    input  logic                 load,
`ifdef FRAC_DIV_ALIGN_EN
    input  logic                 align,
`endif
    input  logic [NCH*WIDTH-1:0] n_in,
    input  logic [NCH*FW-1:0]    frac_in,
    input  logic [NCH*WIDTH-1:0] duty_in,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       q_out,
    output logic [NCH-1:0]       tc,
    output logic [NCH-1:0]       pending
);

    logic d1, d2, tick, align_fire;

    always_ff @(posedge sys_clk) begin
        if (sync_rst) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= clk_in;
            d2 <= d1;
        end
    end

    assign tick = d1 & ~d2;

`ifdef FRAC_DIV_ALIGN_EN
    logic armed;

    // An align strobe stays armed until the next tick; a strobe on a tick acts at once.
    always_ff @(posedge sys_clk) begin
        if (sync_rst) armed <= 1'b0;
        else          armed <= (armed | align) & ~tick;
    end

    assign align_fire = tick & (armed | align);
`else
    assign align_fire = 1'b0;
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [WIDTH-1:0] m_q, m_nxt, na_q, da_q, pn_q, pd_q, n_eff, d_eff;
        logic [FW-1:0]    acc_q, acc_nxt, fa_q, pf_q, f_eff;
        logic [FW:0]      sum;
        logic             pend_q, tc_q, tc_nxt, reload, apply;

        // Pending settings take over while idle or on this cycle's reload/align; a load in
        // the same cycle only lands in the pending registers, so the reload sees older values.
        always_comb begin
            reload  = tick & en[k] & (m_q == WIDTH'(1));
            apply   = pend_q & ((m_q == '0) | reload | (align_fire & en[k]));
            n_eff   = apply ? pn_q : na_q;
            f_eff   = apply ? pf_q : fa_q;
            d_eff   = apply ? pd_q : da_q;
            sum     = {1'b0, acc_q} + {1'b0, f_eff};
            m_nxt   = m_q;
            acc_nxt = acc_q;
            tc_nxt  = 1'b0;
            if (!en[k]) begin
                m_nxt   = '0;
                acc_nxt = '0;
            end else if (align_fire && (n_eff >= WIDTH'(2))) begin
                m_nxt   = n_eff;
                acc_nxt = '0;
                tc_nxt  = 1'b1;
            end else if (tick) begin
                if (m_q == '0) begin
                    if (n_eff >= WIDTH'(2)) begin
                        m_nxt  = n_eff;
                        tc_nxt = 1'b1;
                    end
                end else if (reload) begin
                    // Carry is dropped at the maximum divisor so the count cannot wrap.
                    acc_nxt = sum[FW-1:0];
                    m_nxt   = (n_eff == '1) ? n_eff : n_eff + WIDTH'(sum[FW]);
                    tc_nxt  = 1'b1;
                end else begin
                    m_nxt = m_q - WIDTH'(1);
                end
            end
        end

        always_ff @(posedge sys_clk) begin
            if (sync_rst) begin
                m_q    <= '0;
                acc_q  <= '0;
                tc_q   <= 1'b0;
                na_q   <= '0;
                fa_q   <= '0;
                da_q   <= '0;
                pn_q   <= '0;
                pf_q   <= '0;
                pd_q   <= '0;
                pend_q <= 1'b0;
            end else begin
                m_q   <= m_nxt;
                acc_q <= acc_nxt;
                tc_q  <= tc_nxt;
                na_q  <= n_eff;
                fa_q  <= f_eff;
                da_q  <= d_eff;
                if (load) begin
                    pn_q   <= n_in[k*WIDTH +: WIDTH];
                    pf_q   <= frac_in[k*FW +: FW];
                    pd_q   <= duty_in[k*WIDTH +: WIDTH];
                    pend_q <= 1'b1;
                end else if (apply) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign count[k*WIDTH +: WIDTH] = m_q;
        assign q_out[k]                = en[k] & (m_q > da_q);
        assign tc[k]                   = tc_q;
        assign pending[k]              = pend_q;
    end

endmodule

// File: tb/tb_frac_div_mc.sv
// Self-checking bench for frac_div_mc: cycle-by-cycle comparison against a behavioural model
// plus hand-computed period/sequence expectations; the align section needs FRAC_DIV_ALIGN_EN.
module tb_frac_div_mc;
    localparam int NCH   = 2;
    localparam int WIDTH = 8;
    localparam int FW    = 4;
    localparam int MAXN  = (1 << WIDTH) - 1;
    localparam int FMOD  = 1 << FW;

    logic                 sys_clk  = 1'b0;
    logic                 sync_rst = 1'b1;
    logic                 clk_in   = 1'b0;
    logic [NCH-1:0]       en       = '0;
    logic                 load     = 1'b0;
`ifdef FRAC_DIV_ALIGN_EN
    logic                 align    = 1'b0;
`endif
    logic [NCH*WIDTH-1:0] n_in     = '0;
    logic [NCH*FW-1:0]    frac_in  = '0;
    logic [NCH*WIDTH-1:0] duty_in  = '0;
    logic [NCH*WIDTH-1:0] count;
    logic [NCH-1:0]       q_out;
    logic [NCH-1:0]       tc;
    logic [NCH-1:0]       pending;

    frac_div_mc #(.NCH(NCH), .WIDTH(WIDTH), .FW(FW)) dut (
        .sys_clk (sys_clk),
        .sync_rst(sync_rst),
        .clk_in  (clk_in),
        .en      (en),
        .load    (load),
`ifdef FRAC_DIV_ALIGN_EN
        .align   (align),
`endif
        .n_in    (n_in),
        .frac_in (frac_in),
        .duty_in (duty_in),
        .count   (count),
        .q_out   (q_out),
        .tc      (tc),
        .pending (pending)
    );

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Reference clock: random high/low durations of 1..3 system cycles while running.
    bit ref_run  = 1'b0;
    int ref_left = 0;
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!ref_run) begin
                clk_in   = 1'b0;
                ref_left = 0;
            end else if (ref_left == 0) begin
                clk_in   = ~clk_in;
                ref_left = $urandom_range(0, 2);
            end else begin
                ref_left--;
            end
        end
    end

    // Behavioural model state
    int m_cnt[NCH], m_acc[NCH], m_na[NCH], m_fa[NCH], m_da[NCH], m_pn[NCH], m_pf[NCH], m_pd[NCH];
    bit m_pend[NCH], m_tc[NCH];
    bit h0, h1;          // clk_in as seen at the last and second-to-last clock edge
    bit m_armed, model_valid, last_tick;
    int n_ticks = 0;
    int cnt0_log[$], q0_log[$], tc0_at[$], tc1_at[$];

    task automatic model_step();
        bit tk, fire, al, rl, app;
        int en_n, en_f, en_d, s;
        al = 1'b0;
`ifdef FRAC_DIV_ALIGN_EN
        al = align;
`endif
        // A reference rising edge is recognised once it was seen high after being seen low.
        tk = h0 && !h1;
        if (sync_rst) begin
            for (int k = 0; k < NCH; k++) begin
                m_cnt[k] = 0; m_acc[k] = 0; m_na[k] = 0; m_fa[k] = 0; m_da[k] = 0;
                m_pn[k] = 0; m_pf[k] = 0; m_pd[k] = 0; m_pend[k] = 0; m_tc[k] = 0;
            end
            h0 = 0; h1 = 0; m_armed = 0; model_valid = 1;
            last_tick = 0;
        end else begin
            fire = tk && (m_armed || al);
            for (int k = 0; k < NCH; k++) begin
                rl   = tk && en[k] && (m_cnt[k] == 1);
                app  = m_pend[k] && (m_cnt[k] == 0 || rl || (fire && en[k]));
                en_n = app ? m_pn[k] : m_na[k];
                en_f = app ? m_pf[k] : m_fa[k];
                en_d = app ? m_pd[k] : m_da[k];
                m_tc[k] = 0;
                if (!en[k]) begin
                    m_cnt[k] = 0;
                    m_acc[k] = 0;
                end else if (fire && en_n >= 2) begin
                    m_cnt[k] = en_n;
                    m_acc[k] = 0;
                    m_tc[k]  = 1;
                end else if (tk) begin
                    if (m_cnt[k] == 0) begin
                        if (en_n >= 2) begin
                            m_cnt[k] = en_n;
                            m_tc[k]  = 1;
                        end
                    end else if (m_cnt[k] == 1) begin
                        s        = m_acc[k] + en_f;
                        m_acc[k] = s % FMOD;
                        m_cnt[k] = (en_n == MAXN) ? en_n : en_n + s / FMOD;
                        m_tc[k]  = 1;
                    end else begin
                        m_cnt[k] = m_cnt[k] - 1;
                    end
                end
                m_na[k] = en_n; m_fa[k] = en_f; m_da[k] = en_d;
                if (load) begin
                    m_pn[k]   = int'(n_in[k*WIDTH +: WIDTH]);
                    m_pf[k]   = int'(frac_in[k*FW +: FW]);
                    m_pd[k]   = int'(duty_in[k*WIDTH +: WIDTH]);
                    m_pend[k] = 1;
                end else if (app) begin
                    m_pend[k] = 0;
                end
            end
            m_armed   = (m_armed || al) && !tk;
            h1        = h0;
            h0        = clk_in;
            last_tick = tk;
        end
    endtask

    // Compare process: advance the model at the edge, compare shortly after.
    always @(posedge sys_clk) begin
        model_step();
        #2;
        if (model_valid) begin
            for (int k = 0; k < NCH; k++) begin
                check($sformatf("count%0d", k), 32'(count[k*WIDTH +: WIDTH]), 32'(m_cnt[k]));
                check($sformatf("q_out%0d", k), 32'(q_out[k]), 32'((m_cnt[k] > m_da[k]) && en[k]));
                check($sformatf("tc%0d", k), 32'(tc[k]), 32'(m_tc[k]));
                check($sformatf("pending%0d", k), 32'(pending[k]), 32'(m_pend[k]));
            end
        end
        if (last_tick) begin
            n_ticks++;
            cnt0_log.push_back(int'(count[WIDTH-1:0]));
            q0_log.push_back(int'(q_out[0]));
        end
        if (tc[0] === 1'b1) tc0_at.push_back(n_ticks);
        if (tc[1] === 1'b1) tc1_at.push_back(n_ticks);
    end

    task automatic do_load(input int n0, input int f0, input int d0,
                           input int n1, input int f1, input int d1);
        n_in[0 +: WIDTH]     = WIDTH'(n0);
        n_in[WIDTH +: WIDTH] = WIDTH'(n1);
        frac_in[0 +: FW]     = FW'(f0);
        frac_in[FW +: FW]    = FW'(f1);
        duty_in[0 +: WIDTH]  = WIDTH'(d0);
        duty_in[WIDTH +: WIDTH] = WIDTH'(d1);
        load = 1'b1;
        @(negedge sys_clk);
        load = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int target, b;
        target = n_ticks + n;
        b = 0;
        while (n_ticks < target && b < 20000) begin
            @(negedge sys_clk);
            b++;
        end
        if (n_ticks < target) fail_timeout("ticks");
    endtask

    task automatic wait_tc(input int k, input int budget);
        int b;
        b = 0;
        @(negedge sys_clk);
        while (tc[k] !== 1'b1 && b < budget) begin
            @(negedge sys_clk);
            b++;
        end
        if (tc[k] !== 1'b1) fail_timeout("tc");
    endtask

    task automatic wait_count(input int k, input int v);
        int b;
        b = 0;
        while (int'(count[k*WIDTH +: WIDTH]) != v && b < 2000) begin
            @(negedge sys_clk);
            b++;
        end
        if (int'(count[k*WIDTH +: WIDTH]) != v) fail_timeout("count_value");
    endtask

    initial begin
        int exp1[10] = '{5, 4, 3, 2, 1, 5, 4, 3, 2, 1};
        int exp2[5]  = '{4, 4, 5, 4, 5};
        int start, hi, sum, b, rn;

        // 1: reset, then N=5/F=0/D=2 on ch0
        repeat (3) @(negedge sys_clk);
        sync_rst = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_tc", 32'(tc), 32'd0);
        check("rst_q", 32'(q_out), 32'd0);
        en = 2'b01;
        do_load(5, 0, 2, 0, 0, 0);
        @(negedge sys_clk);
        cnt0_log.delete(); q0_log.delete(); tc0_at.delete();
        start = n_ticks;
        ref_run = 1'b1;
        wait_ticks(10);
        check("t1_len", 32'(cnt0_log.size() >= 10), 32'd1);
        hi = 0;
        if (cnt0_log.size() >= 10) begin
            for (int i = 0; i < 10; i++) begin
                check("t1_seq", 32'(cnt0_log[i]), 32'(exp1[i]));
                hi += q0_log[i];
            end
        end
        check("t1_qhigh", 32'(hi), 32'd6);
        check("t1_tc_n", 32'(tc0_at.size()), 32'd2);
        if (tc0_at.size() >= 2) begin
            check("t1_tc_first", 32'(tc0_at[0] - start), 32'd1);
            check("t1_tc_second", 32'(tc0_at[1] - start), 32'd6);
        end

        // 2: ch1 N=4 F=8 -> periods 4,4,5,4,5..., 20 periods sum to 90
        en = 2'b10;
        tc1_at.delete();
        do_load(5, 0, 2, 4, 8, 1);
        b = 0;
        while (tc1_at.size() < 22 && b < 6000) begin
            @(negedge sys_clk);
            b++;
        end
        if (tc1_at.size() < 22) fail_timeout("t2_periods");
        else begin
            for (int i = 0; i < 5; i++)
                check("t2_period", 32'(tc1_at[i+1] - tc1_at[i]), 32'(exp2[i]));
            sum = 0;
            for (int i = 1; i <= 20; i++) sum += tc1_at[i+1] - tc1_at[i];
            check("t2_sum20", 32'(sum), 32'd90);
        end

        // 3: mid-count load waits for the reload; earlier period still 5
        en = 2'b01;
        do_load(5, 0, 2, 4, 8, 1);
        wait_tc(0, 500);
        tc0_at.delete();
        wait_tc(0, 500);
        wait_count(0, 3);
        do_load(7, 0, 2, 4, 8, 1);
        check("t3_pending_set", 32'(pending[0]), 32'd1);
        wait_tc(0, 500);
        check("t3_reload7", 32'(count[WIDTH-1:0]), 32'd7);
        check("t3_pending_clr", 32'(pending[0]), 32'd0);
        if (tc0_at.size() >= 2) check("t3_old_period", 32'(tc0_at[1] - tc0_at[0]), 32'd5);
        else fail_timeout("t3_tc_log");

        // 3b: load coinciding with the M==1 tick
        do_load(5, 0, 2, 4, 8, 1);
        wait_tc(0, 500);
        wait_tc(0, 500);
        b = 0;
        while (!(int'(count[WIDTH-1:0]) == 1 && h0 && !h1) && b < 500) begin
            @(negedge sys_clk);
            b++;
        end
        if (!(int'(count[WIDTH-1:0]) == 1 && h0 && !h1)) fail_timeout("t3_coinc");
        do_load(7, 0, 2, 4, 8, 1);
        check("t3_coinc_cnt", 32'(count[WIDTH-1:0]), 32'd5);
        check("t3_coinc_tc", 32'(tc[0]), 32'd1);
        check("t3_coinc_pend", 32'(pending[0]), 32'd1);
        wait_tc(0, 500);
        check("t3_coinc_next", 32'(count[WIDTH-1:0]), 32'd7);

        // 4: drop en mid-count, then restart from idle
        wait_count(0, 3);
        en = 2'b00;
        @(negedge sys_clk);
        check("t4_cnt0", 32'(count[WIDTH-1:0]), 32'd0);
        check("t4_q0", 32'(q_out[0]), 32'd0);
        en = 2'b01;
        wait_tc(0, 200);
        check("t4_restart", 32'(count[WIDTH-1:0]), 32'd7);

        // 5: maximum divisor never wraps; N=1 stays idle
        en = 2'b00;
        do_load(MAXN, FMOD - 1, 100, 4, 8, 1);
        en = 2'b01;
        for (int i = 0; i < 3; i++) begin
            wait_tc(0, 3000);
            check("t5_max", 32'(count[WIDTH-1:0]), 32'(MAXN));
            check("t5_q", 32'(q_out[0]), 32'd1);
        end
        en = 2'b00;
        do_load(1, 0, 0, 4, 8, 1);
        @(negedge sys_clk);
        en = 2'b01;
        tc0_at.delete();
        wait_ticks(6);
        check("t5_n1_cnt", 32'(count[WIDTH-1:0]), 32'd0);
        check("t5_n1_q", 32'(q_out[0]), 32'd0);
        check("t5_n1_tc", 32'(tc0_at.size()), 32'd0);

`ifdef FRAC_DIV_ALIGN_EN
        // 6: align two free-running channels onto one tick
        en = 2'b00;
        do_load(5, 0, 2, 7, 0, 3);
        en = 2'b11;
        wait_ticks(13);
        align = 1'b1;
        @(negedge sys_clk);
        align = 1'b0;
        b = 0;
        while (tc == '0 && b < 200) begin
            @(negedge sys_clk);
            b++;
        end
        check("t6_tc_both", 32'(tc), 32'd3);
        check("t6_cnt0", 32'(count[WIDTH-1:0]), 32'd5);
        check("t6_cnt1", 32'(count[2*WIDTH-1:WIDTH]), 32'd7);
`endif

        // Random phase: model checks every cycle
        for (int c = 0; c < 1500; c++) begin
            @(negedge sys_clk);
            load = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < NCH; k++) begin
                    rn = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MAXN)) : int'($urandom_range(0, 12));
                    n_in[k*WIDTH +: WIDTH]    = WIDTH'(rn);
                    frac_in[k*FW +: FW]       = FW'($urandom_range(0, FMOD - 1));
                    duty_in[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 12));
                end
                load = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) en = NCH'($urandom);
`ifdef FRAC_DIV_ALIGN_EN
            align = ($urandom_range(0, 49) == 0);
`endif
        end

        // Reset dominates load, en and tick
        sync_rst = 1'b1;
        load     = 1'b1;
        en       = '1;
`ifdef FRAC_DIV_ALIGN_EN
        align    = 1'b1;
`endif
        @(negedge sys_clk);
        check("rst2_count", 32'(count), 32'd0);
        check("rst2_pending", 32'(pending), 32'd0);
        check("rst2_tc", 32'(tc), 32'd0);
        check("rst2_q", 32'(q_out), 32'd0);
        sync_rst = 1'b0;
        load     = 1'b0;
`ifdef FRAC_DIV_ALIGN_EN
        align    = 1'b0;
`endif
        repeat (4) @(negedge sys_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frac_div_mc.md
Name: frac_div_mc

Overview:
- Multi-channel fractional-N down-counter divider. Successor to the single-channel integer divider.
- Samples one external reference clock `clk_in` on `sys_clk` and detects its rising edges.
- Per channel, divides that edge stream by N + FRAC/2^FW using a first-order accumulator, and produces a PWM-style output with a programmable duty threshold.
- New settings are double-buffered and take effect glitch-free at terminal count. Feeds the fractional PWM output stage.

Parameters:
- NCH, 2, number of independent channels.
- WIDTH, 17, integer divide/count width.
- FW, 8, fractional accumulator width.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sync_rst  input  1  synchronous, active-high reset.
- clk_in  input  1  asynchronous reference clock to be divided.
- en  input  NCH  per-channel enable.
- load  input  1  one-cycle strobe; captures n_in/frac_in/duty_in for all channels into pending registers.
- n_in  input  NCH*WIDTH  packed integer divisors; channel k at [k*WIDTH +: WIDTH].
- frac_in  input  NCH*FW  packed fractional parts.
- duty_in  input  NCH*WIDTH  packed duty thresholds.
- count  output  NCH*WIDTH  packed current counter values M.
- q_out  output  NCH  divided/PWM outputs.
- tc  output  NCH  one-cycle terminal-count pulses.
- pending  output  NCH  captured settings not yet applied.

Behaviour:
- **Input sampling:** 2-FF synchronizer on clk_in (d1, d2). tick = d1 & ~d2, shared by all channels.
- **Reset:** d1, d2, M, acc, tc and pending = 0. Active and pending N/FRAC/DUTY = 0. q_out = 0, count = 0.
- **Per-channel state:** M[WIDTH], acc[FW], and active registers Na, Fa, Da.
- **q_out[k]** = (M > Da) and en[k]. Combinational from registers; zero added latency.
- **load:** every channel captures its inputs into pending registers and sets pending[k]. A load while pending is already set overwrites the pending values (last write wins).
- **Applying pending values:** pending values are copied to active registers and pending[k] clears when either:
  - (a) channel is idle (M == 0), or
  - (b) at a reload event.
- **Load coinciding with a reload:** the reload in that same cycle uses the previous pending/active values; the new values apply at the next reload.
- **Idle (M == 0) with en[k] high:**
  - Na < 2: channel stays idle.
  - Otherwise, on tick: M <= Na, acc unchanged, tc[k] = 1.
- **Counting:** on tick with M > 1, M <= M - 1.
- **Terminal count (reload event):** on tick with M == 1:
  - {carry, acc} <= acc + Fa (FW+1-bit sum).
  - M <= Na + carry.
  - tc[k] = 1 in the same cycle M shows the reloaded value.
  - If Na == 2^WIDTH - 1, carry is ignored (no overflow). acc still updates.
- **Long-run period:** average = Na + Fa/2^FW ticks. Na legal range is 2..2^WIDTH-1.
- **en[k] low:** M <= 0, acc <= 0, tc = 0, q_out = 0. Any pending values apply immediately (idle rule).
- **en[k] deasserted mid-count:** count abandoned. Restart is always from idle.
- **Reset mid-operation:** reset dominates load, tick and en.

Optional Feature:
- Macro: FRAC_DIV_ALIGN_EN.
- **With the macro:**
  - Adds input port `align` (1 bit), placed after `load`.
  - An align strobe arms all channels.
  - On the next tick, every enabled channel with Na ≥ 2 (after applying pending) performs M <= Na, acc <= 0 and pulses tc, regardless of its current M.
  - align coincident with tick acts on that tick.
  - Result: channels are phase-aligned to a common edge.
- **Without the macro:** port absent; no alignment logic.

Test Plan:
1. Reset, then NCH=2, WIDTH=8, FW=4; load ch0 N=5/F=0/D=2, en=01 → count per tick 5,4,3,2,1,5,...; q_out[0] high for 3 of every 5 ticks; tc[0] every 5 ticks.
2. ch1 N=4/F=8/D=1, en=10 → reload periods 4,4,5,4,5,... (first load from idle, then alternating); mean 4.5 over 20 periods.
3. Mid-count load of ch0 N=7 at M=3 → pending=1 until the next reload, which loads 7; earlier periods still 5. Load coinciding with M==1 tick → that reload loads 5, next loads 7.
4. Deassert en[0] at M=3 → next cycle count=0, q_out=0; re-enable → first tick loads Na, tc pulses.
5. N=255, F=15, WIDTH=8 → M never exceeds 255, no wrap. N=1 → channel remains idle, q_out=0.
6. (FRAC_DIV_ALIGN_EN) ch0 N=5, ch1 N=7 free-running; pulse align → both tc pulse on the same cycle; counts 5 and 7; acc=0.
